// File: rtl/multi_cycle_pkg.sv
// Shared encodings for the multicycle CPU: opcodes, funct codes, ALU
// control codes, ALUOp codes, datapath mux selects and controller states.
package multi_cycle_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b000010;
    localparam logic [5:0] OP_LW    = 6'b010000;
    localparam logic [5:0] OP_SW    = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b100000;

    localparam logic [5:0] FUNCT_ADD = 6'b000000;
    localparam logic [5:0] FUNCT_SUB = 6'b000010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Second ALU operand sources
    typedef enum logic [1:0] {
        SRCB_B,
        SRCB_FOUR,
        SRCB_SIMM,
        SRCB_SIMM_SHL2
    } srcb_t;

    // Next-PC sources
    typedef enum logic [1:0] {
        PC_FROM_ALU,
        PC_FROM_ALUOUT,
        PC_FROM_JUMP
    } pc_src_t;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADDR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXEC,
        RWB,
        ADDIEX,
        ADDIWB,
        BRANCH,
        JUMP
    } state_t;

endpackage

// File: rtl/multi_cycle_alu.sv
// ALU control decoding plus the 32-bit ALU shared by every datapath step.
module mc_alu
    import multi_cycle_pkg::*;
(
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [1:0]  alu_op,
    input  logic [5:0]  funct,
    output logic [31:0] result,
    output logic        zero
);

    logic [3:0] alu_ctrl;

    // Map ALUOp (and funct for R-type) to an ALU operation; unknown funct adds
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_SUB: alu_ctrl = ALU_SUB;
                    FUNCT_AND: alu_ctrl = ALU_AND;
                    FUNCT_OR:  alu_ctrl = ALU_OR;
                    FUNCT_SLT: alu_ctrl = ALU_SLT;
                    default:   alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

    // Perform the selected operation; slt compares as signed
    always_comb begin
        result = src_a + src_b;
        case (alu_ctrl)
            ALU_SUB: result = src_a - src_b;
            ALU_AND: result = src_a & src_b;
            ALU_OR:  result = src_a | src_b;
            ALU_SLT: result = ($signed(src_a) < $signed(src_b)) ? 32'd1 : 32'd0;
            default: result = src_a + src_b;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/multi_cycle.sv
// Multicycle 32-bit CPU: FSM controller, datapath registers, register file
// and a 32-word memory preloaded from the in0..in31 ports during reset.
module multi_cycle
    import multi_cycle_pkg::*;
(
    input logic        clk,
    input logic        reset,
    input logic [31:0] in0,  input logic [31:0] in1,  input logic [31:0] in2,  input logic [31:0] in3,
    input logic [31:0] in4,  input logic [31:0] in5,  input logic [31:0] in6,  input logic [31:0] in7,
    input logic [31:0] in8,  input logic [31:0] in9,  input logic [31:0] in10, input logic [31:0] in11,
    input logic [31:0] in12, input logic [31:0] in13, input logic [31:0] in14, input logic [31:0] in15,
    input logic [31:0] in16, input logic [31:0] in17, input logic [31:0] in18, input logic [31:0] in19,
    input logic [31:0] in20, input logic [31:0] in21, input logic [31:0] in22, input logic [31:0] in23,
    input logic [31:0] in24, input logic [31:0] in25, input logic [31:0] in26, input logic [31:0] in27,
    input logic [31:0] in28, input logic [31:0] in29, input logic [31:0] in30, input logic [31:0] in31
);

    state_t      state, next_state;
    logic [31:0] pc, ir, mdr, a, b, alu_out;
    logic [31:0] regs [32];
    logic [31:0] mem  [32];
    logic [31:0] init_words [32];

    logic        pc_write, ir_write, mdr_write, ab_write, alu_out_write;
    logic        mem_write, addr_from_alu_out, reg_write, reg_dst_rd, mem_to_reg, alu_src_a_reg;
    pc_src_t     pc_src;
    srcb_t       alu_src_b;
    logic [1:0]  alu_op;

    logic [31:0] simm, mem_addr, mem_rdata, alu_a, alu_b, alu_result, pc_next, wb_data;
    logic [4:0]  wb_addr;
    logic        alu_zero;
    logic        unused_addr_bits;

    assign init_words[0]  = in0;  assign init_words[1]  = in1;  assign init_words[2]  = in2;  assign init_words[3]  = in3;
    assign init_words[4]  = in4;  assign init_words[5]  = in5;  assign init_words[6]  = in6;  assign init_words[7]  = in7;
    assign init_words[8]  = in8;  assign init_words[9]  = in9;  assign init_words[10] = in10; assign init_words[11] = in11;
    assign init_words[12] = in12; assign init_words[13] = in13; assign init_words[14] = in14; assign init_words[15] = in15;
    assign init_words[16] = in16; assign init_words[17] = in17; assign init_words[18] = in18; assign init_words[19] = in19;
    assign init_words[20] = in20; assign init_words[21] = in21; assign init_words[22] = in22; assign init_words[23] = in23;
    assign init_words[24] = in24; assign init_words[25] = in25; assign init_words[26] = in26; assign init_words[27] = in27;
    assign init_words[28] = in28; assign init_words[29] = in29; assign init_words[30] = in30; assign init_words[31] = in31;

    assign simm             = {{16{ir[15]}}, ir[15:0]};
    assign mem_addr         = addr_from_alu_out ? alu_out : pc;
    assign mem_rdata        = mem[mem_addr[6:2]];
    assign unused_addr_bits = ^{mem_addr[31:7], mem_addr[1:0]};
    assign alu_a            = alu_src_a_reg ? a : pc;
    assign wb_addr          = reg_dst_rd ? ir[15:11] : ir[20:16];
    assign wb_data          = mem_to_reg ? mdr : alu_out;

    // Second ALU operand selection
    always_comb begin
        case (alu_src_b)
            SRCB_FOUR:      alu_b = 32'd4;
            SRCB_SIMM:      alu_b = simm;
            SRCB_SIMM_SHL2: alu_b = {simm[29:0], 2'b00};
            default:        alu_b = b;
        endcase
    end

    // Next-PC selection: sequential, branch target held in ALUOut, or jump
    always_comb begin
        case (pc_src)
            PC_FROM_ALUOUT: pc_next = alu_out;
            PC_FROM_JUMP:   pc_next = {pc[31:28], ir[25:0], 2'b00};
            default:        pc_next = alu_result;
        endcase
    end

    mc_alu u_alu (
        .src_a  (alu_a),
        .src_b  (alu_b),
        .alu_op (alu_op),
        .funct  (ir[5:0]),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // Controller state register
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    // Controller next-state and per-state datapath controls
    always_comb begin
        next_state        = FETCH;
        pc_write          = 1'b0;
        pc_src            = PC_FROM_ALU;
        ir_write          = 1'b0;
        mdr_write         = 1'b0;
        ab_write          = 1'b0;
        alu_out_write     = 1'b0;
        mem_write         = 1'b0;
        addr_from_alu_out = 1'b0;
        reg_write         = 1'b0;
        reg_dst_rd        = 1'b0;
        mem_to_reg        = 1'b0;
        alu_src_a_reg     = 1'b0;
        alu_src_b         = SRCB_B;
        alu_op            = ALUOP_ADD;
        case (state)
            FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_b  = SRCB_FOUR;
                next_state = DECODE;
            end
            DECODE: begin
                ab_write      = 1'b1;
                alu_out_write = 1'b1;
                alu_src_b     = SRCB_SIMM_SHL2;
                case (ir[31:26])
                    OP_LW, OP_SW: next_state = MEMADDR;
                    OP_RTYPE:     next_state = EXEC;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_BEQ:       next_state = BRANCH;
                    OP_J:         next_state = JUMP;
                    default:      next_state = FETCH;
                endcase
            end
            MEMADDR, ADDIEX: begin
                alu_out_write = 1'b1;
                alu_src_a_reg = 1'b1;
                alu_src_b     = SRCB_SIMM;
                if (state == ADDIEX)          next_state = ADDIWB;
                else if (ir[31:26] == OP_LW)  next_state = MEMRD;
                else                          next_state = MEMWR;
            end
            MEMRD: begin
                addr_from_alu_out = 1'b1;
                mdr_write         = 1'b1;
                next_state        = MEMWB;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                addr_from_alu_out = 1'b1;
                mem_write         = 1'b1;
            end
            EXEC: begin
                alu_out_write = 1'b1;
                alu_src_a_reg = 1'b1;
                alu_op        = ALUOP_FUNCT;
                next_state    = RWB;
            end
            RWB: begin
                reg_write  = 1'b1;
                reg_dst_rd = 1'b1;
            end
            ADDIWB: begin
                reg_write = 1'b1;
            end
            BRANCH: begin
                alu_src_a_reg = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_src        = PC_FROM_ALUOUT;
                pc_write      = alu_zero;
            end
            JUMP: begin
                pc_src   = PC_FROM_JUMP;
                pc_write = 1'b1;
            end
            default: next_state = FETCH;
        endcase
    end

    // Datapath registers loaded under controller enables
    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= '0;
            ir      <= 32'hFFFF_FFFF;
            mdr     <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
        end else begin
            if (pc_write)      pc      <= pc_next;
            if (ir_write)      ir      <= mem_rdata;
            if (mdr_write)     mdr     <= mem_rdata;
            if (alu_out_write) alu_out <= alu_result;
            if (ab_write) begin
                a <= regs[ir[25:21]];
                b <= regs[ir[20:16]];
            end
        end
    end

    // Register file write port; r0 is an ordinary register
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 32; k++) regs[k] <= '0;
        end else if (reg_write) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Memory preload during reset, otherwise store-word writes
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 32; k++) mem[k] <= init_words[k];
        end else if (mem_write) begin
            mem[mem_addr[6:2]] <= b;
        end
    end

endmodule

// File: tb/tb_multi_cycle.sv
// Directed bench for the multicycle CPU; state is observed hierarchically.
module tb_multi_cycle;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] prog [32];
    int          compared = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;

    multi_cycle dut (
        .clk(clk), .reset(reset),
        .in0(prog[0]),   .in1(prog[1]),   .in2(prog[2]),   .in3(prog[3]),
        .in4(prog[4]),   .in5(prog[5]),   .in6(prog[6]),   .in7(prog[7]),
        .in8(prog[8]),   .in9(prog[9]),   .in10(prog[10]), .in11(prog[11]),
        .in12(prog[12]), .in13(prog[13]), .in14(prog[14]), .in15(prog[15]),
        .in16(prog[16]), .in17(prog[17]), .in18(prog[18]), .in19(prog[19]),
        .in20(prog[20]), .in21(prog[21]), .in22(prog[22]), .in23(prog[23]),
        .in24(prog[24]), .in25(prog[25]), .in26(prog[26]), .in27(prog[27]),
        .in28(prog[28]), .in29(prog[29]), .in30(prog[30]), .in31(prog[31])
    );

    // Instruction encoders using literal opcode fields
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'b000000, rs, rt, rd, 5'b00000, funct};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // One reset cycle, sampled at the next rising edge, released at negedge
    task automatic applyStimulus();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic runCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Main program: arithmetic, memory, slt, default funct, jump
        for (int k = 0; k < 32; k++) prog[k] = 32'h0;
        prog[0]  = enc_i(6'b000010, 5'd0, 5'd2, 16'd5);        // addi r2 = 5
        prog[1]  = enc_i(6'b000010, 5'd0, 5'd3, 16'd7);        // addi r3 = 7
        prog[2]  = enc_r(5'd2, 5'd3, 5'd4, 6'b000000);         // add r4 = 12
        prog[3]  = enc_r(5'd4, 5'd3, 5'd5, 6'b000010);         // sub r5 = 5
        prog[4]  = enc_i(6'b001000, 5'd0, 5'd2, 16'h0040);     // sw r2 -> word 16
        prog[5]  = enc_i(6'b010000, 5'd0, 5'd6, 16'h0040);     // lw r6 <- word 16
        prog[6]  = enc_r(5'd4, 5'd3, 5'd7, 6'b100100);         // and r7 = 4
        prog[7]  = enc_r(5'd4, 5'd3, 5'd8, 6'b100101);         // or r8 = 15
        prog[8]  = enc_i(6'b000010, 5'd0, 5'd1, 16'hFFFF);     // addi r1 = -1
        prog[9]  = enc_r(5'd1, 5'd2, 5'd9, 6'b101010);         // slt r9 = 1
        prog[10] = enc_r(5'd2, 5'd1, 5'd4, 6'b101010);         // slt r4 = 0
        prog[11] = enc_r(5'd2, 5'd3, 5'd11, 6'b000111);        // unknown funct -> add = 12
        prog[12] = {6'b100000, 26'd4};                         // j 0x10
        prog[16] = 32'hDEAD_BEEF;

        applyStimulus();
        checkOutput("reset_pc", dut.pc, 32'h0);
        checkOutput("reset_ir", dut.ir, 32'hFFFF_FFFF);
        checkOutput("reset_state", 32'(dut.state), 32'd0);
        checkOutput("reset_mem16", dut.mem[16], 32'hDEAD_BEEF);
        runCycles(1);
        checkOutput("fetch_pc", dut.pc, 32'h4);
        checkOutput("fetch_ir", dut.ir, 32'h0802_0005);
        for (int k = 0; k < 32; k++) checkOutput($sformatf("fetch_r%0d", k), dut.regs[k], 32'h0);
        runCycles(3);
        checkOutput("addi_r2", dut.regs[2], 32'd5);
        checkOutput("addi_pc", dut.pc, 32'h4);
        runCycles(4);
        checkOutput("addi_r3", dut.regs[3], 32'd7);
        runCycles(4);
        checkOutput("add_r4", dut.regs[4], 32'd12);
        runCycles(4);
        checkOutput("sub_r5", dut.regs[5], 32'd5);
        runCycles(4);
        checkOutput("sw_mem16", dut.mem[16], 32'd5);
        runCycles(4);
        checkOutput("lw_not_yet", dut.regs[6], 32'd0);
        runCycles(1);
        checkOutput("lw_r6", dut.regs[6], 32'd5);
        runCycles(4);
        checkOutput("and_r7", dut.regs[7], 32'd4);
        runCycles(4);
        checkOutput("or_r8", dut.regs[8], 32'd15);
        runCycles(4);
        checkOutput("addi_neg_r1", dut.regs[1], 32'hFFFF_FFFF);
        runCycles(4);
        checkOutput("slt_true_r9", dut.regs[9], 32'd1);
        runCycles(4);
        checkOutput("slt_false_r4", dut.regs[4], 32'd0);
        runCycles(4);
        checkOutput("funct_default_r11", dut.regs[11], 32'd12);
        checkOutput("pre_jump_pc", dut.pc, 32'h30);
        runCycles(3);
        checkOutput("jump_pc", dut.pc, 32'h10);
        checkOutput("jump_state", 32'(dut.state), 32'd0);

        // Unknown opcode, then beq taken at PC=8 with r0 == r0
        for (int k = 0; k < 32; k++) prog[k] = 32'h0;
        prog[0]  = 32'hFFFF_FFFF;
        prog[1]  = enc_i(6'b000010, 5'd0, 5'd2, 16'd5);
        prog[2]  = enc_i(6'b000100, 5'd0, 5'd0, 16'hFFFE);
        prog[16] = 32'h1111_2222;
        applyStimulus();
        runCycles(2);
        checkOutput("nop_state", 32'(dut.state), 32'd0);
        checkOutput("nop_pc", dut.pc, 32'h4);
        checkOutput("nop_r0", dut.regs[0], 32'h0);
        checkOutput("nop_r31", dut.regs[31], 32'h0);
        checkOutput("nop_mem0", dut.mem[0], 32'hFFFF_FFFF);
        checkOutput("nop_mem16", dut.mem[16], 32'h1111_2222);
        runCycles(4);
        runCycles(3);
        checkOutput("beq_taken_pc", dut.pc, 32'h4);

        // Reset in the middle of an addi aborts it
        runCycles(3);
        checkOutput("mid_state", 32'(dut.state), 32'd9);
        applyStimulus();
        checkOutput("abort_pc", dut.pc, 32'h0);
        checkOutput("abort_state", 32'(dut.state), 32'd0);
        runCycles(1);
        checkOutput("abort_r2", dut.regs[2], 32'h0);

        // beq not taken: r0 != r2
        prog[2] = enc_i(6'b000100, 5'd0, 5'd2, 16'hFFFE);
        applyStimulus();
        runCycles(2 + 4 + 3);
        checkOutput("beq_not_taken_pc", dut.pc, 32'hC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multi_cycle.md
MULTI_CYCLE -- requirements
Module: multi_cycle

Interface
REQ-001 The design SHALL use one clock, clk, and a synchronous, active-high reset, reset.
REQ-002 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 Port reset, input, 1 bit: synchronous active-high reset.
REQ-004 Ports in0..in31, input, 32 bits each: initial contents of memory words 0..31, sampled while reset is high.
REQ-005 The design SHALL have no outputs; state is observed hierarchically via PC, IR, register file, memory and FSM state.

Function
REQ-006 The design SHALL be a multicycle 32-bit CPU: PC, 32x32 memory, IR, MDR, A, B, ALUOut, a 32x32 register file, a FSM controller, ALU control and ALU.
REQ-007 Memory SHALL be word-indexed by addr[6:2] and wrap modulo 32; reads are combinational; writes are synchronous on memWrite.
REQ-008 Opcode IR[31:26], rs IR[25:21], rt IR[20:16], rd IR[15:11], imm IR[15:0] sign-extended, funct IR[5:0].
REQ-009 Opcodes: 000000 R-type; 000010 addi (rt<=rs+simm); 010000 lw (rt<=M[rs+simm]); 001000 sw (M[rs+simm]<=rt); 000100 beq; 100000 j.
REQ-010 R-type funct: 000000 add, 000010 sub, 100100 and, 100101 or, 101010 slt (signed); other funct SHALL perform add.
REQ-011 ALU control: ALUOp 00 -> add, 01 -> sub, 10 -> decoded funct; ALU codes 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt.
REQ-012 ALU zero SHALL be 1 exactly when the 32-bit result is 0; add/sub wrap modulo 2^32.
REQ-013 FETCH: IR<=M[PC], PC<=PC+4; next DECODE.
REQ-014 DECODE: A<=R[rs], B<=R[rt], ALUOut<=PC+(simm<<2); next by opcode: lw/sw -> MEMADDR, R -> EXEC, addi -> ADDIEX, beq -> BRANCH, j -> JUMP, any other opcode -> FETCH.
REQ-015 MEMADDR: ALUOut<=A+simm; next MEMRD (lw) or MEMWR (sw).
REQ-016 MEMRD: MDR<=M[ALUOut]; next MEMWB, which writes R[rt]<=MDR; next FETCH.
REQ-017 MEMWR: M[ALUOut]<=B; next FETCH.
REQ-018 EXEC: ALUOut<=A op B; next RWB, which writes R[rd]<=ALUOut; next FETCH.
REQ-019 ADDIEX: ALUOut<=A+simm; next ADDIWB, which writes R[rt]<=ALUOut; next FETCH.
REQ-020 BRANCH: compute A-B; if zero, PC<=ALUOut; next FETCH.
REQ-021 JUMP: PC<={PC[31:28],IR[25:0],2'b00}; next FETCH.
REQ-022 CPI SHALL be: lw 5, R/addi/sw 4, beq/j 3, unknown opcode 2 (no-op, PC+4).
REQ-023 Register r0 SHALL be an ordinary writable register.
REQ-024 Register-file reads SHALL be combinational; writes occur on the clock edge ending the write-back state.

Reset
REQ-025 While reset is high: PC=0, IR=32'hFFFF_FFFF, MDR/A/B/ALUOut=0, all registers 0, memory word k<=ink, FSM=FETCH.
REQ-026 Reset asserted mid-instruction SHALL abort it with no further register or memory write; execution restarts at FETCH, PC=0.

Structure
REQ-027 A shared package SHALL hold the opcode constants, funct constants, ALU control codes, ALUOp codes and the FSM state enumeration.
REQ-028 The ALU plus ALU control SHALL be one sub-module, mc_alu; the FSM, datapath and memory stay in multi_cycle.

Verification
REQ-029 Reset for 1 cycle, then release -> first FETCH reads in0, PC=4 after one cycle, and all registers are 0.
REQ-030 Test addi with in0=addi rs=0 rt=2 imm=5 -> R2=5 after 4 cycles and PC=4.
REQ-031 Test R-type add and sub with R2=5, R3=7:
- add rd=4 -> R4=12.
- then sub rs=4 rt=3 rd=5 -> R5=5.
- 4 cycles each.
REQ-032 Test store then load with R2=5:
- sw rs=0 rt=2 imm=0x40 -> memory word 16=5 after 4 cycles.
- lw rt=6 same address -> R6=5 after 5 cycles.
REQ-033 Test beq taken with rs=rt at PC=8, imm=-2 -> PC=4 after 3 cycles; with unequal registers PC=12.
REQ-034 Test j and unknown opcode:
- j imm26=4 at PC=0x30 -> PC=0x10 after 3 cycles.
- IR=0xFFFFFFFF -> returns to FETCH after DECODE with no writes.
